// File: rtl/reg_context_seq.sv
// reg_context_seq: register-bench save/restore sequencer.
// Walks the register range FIRST_REG..LAST_REG. A save copies each register
// into a data-memory frame at BASE_ADDR. A restore reloads each register from
// that frame. The control unit is stalled for as long as a sequence runs.
module reg_context_seq #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0F00,
  parameter int          FIRST_REG = 1,
  parameter int          LAST_REG  = 31
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start_save,
  input  logic        start_restore,
  output logic [4:0]  rb_readAddy,
  input  logic [31:0] rb_data,
  output logic [4:0]  rb_writeAddy,
  output logic [31:0] rb_writeData,
  output logic        rb_writeReg,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_write,
  output logic        mem_read,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        cu_stall,
  output logic        busy_save,
  output logic        done
);

  typedef enum logic [2:0] {
    IDLE,
    SAVE,
    LOAD,
    WRITE,
    FIN
  } seqStateT;

  localparam logic [4:0] firstIdx = 5'(FIRST_REG);
  localparam logic [4:0] lastIdx  = 5'(LAST_REG);

  seqStateT    state;
  seqStateT    nextState;
  logic [4:0]  idx;
  logic [31:0] loadData;
  logic [31:0] frameAddr;
  logic        lastOne;

  // Each register's frame slot is one word past the previous register's slot.
  assign frameAddr = BASE_ADDR + (({27'd0, idx} - 32'(FIRST_REG)) << 2);
  assign lastOne   = (idx == lastIdx);

  // Register the state. A reset abandons any sequence that is in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Update the register index and the data-capture register as the walk proceeds.
  always_ff @(posedge clock) begin
    if (reset) begin
      idx      <= firstIdx;
      loadData <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_save || start_restore) begin
            idx <= firstIdx;
          end
        end
        SAVE: begin
          if (mem_ready && !lastOne) begin
            idx <= idx + 5'd1;
          end
        end
        LOAD: begin
          if (mem_ready) begin
            loadData <= mem_rdata;
          end
        end
        WRITE: begin
          if (!lastOne) begin
            idx <= idx + 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Choose the next state. A save request wins over a restore request.
  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (start_save) begin
          nextState = SAVE;
        end else if (start_restore) begin
          nextState = LOAD;
        end
      end
      SAVE: begin
        if (mem_ready) begin
          nextState = lastOne ? FIN : SAVE;
        end
      end
      LOAD: begin
        if (mem_ready) begin
          nextState = WRITE;
        end
      end
      WRITE:   nextState = lastOne ? FIN : LOAD;
      FIN:     nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Drive the outputs from the state. All outputs are held at zero while reset is high,
  // so a register write in progress is suppressed in the reset cycle itself.
  always_comb begin
    rb_readAddy  = '0;
    rb_writeAddy = '0;
    rb_writeData = '0;
    rb_writeReg  = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    mem_write    = 1'b0;
    mem_read     = 1'b0;
    cu_stall     = 1'b0;
    busy_save    = 1'b0;
    done         = 1'b0;
    if (!reset) begin
      case (state)
        SAVE: begin
          rb_readAddy = idx;
          mem_addr    = frameAddr;
          mem_wdata   = rb_data;
          mem_write   = 1'b1;
          cu_stall    = 1'b1;
          busy_save   = 1'b1;
        end
        LOAD: begin
          mem_addr = frameAddr;
          mem_read = 1'b1;
          cu_stall = 1'b1;
        end
        WRITE: begin
          rb_writeAddy = idx;
          rb_writeData = loadData;
          rb_writeReg  = 1'b1;
          cu_stall     = 1'b1;
        end
        FIN: begin
          done     = 1'b1;
          cu_stall = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_context_seq.sv
// Testbench for reg_context_seq. It contains a register-bench model, a
// data-memory model and a frame-level reference for save and restore.
`timescale 1ns/1ps
module tb_reg_context_seq;

  localparam logic [31:0] BASE = 32'h0000_0F00;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset = 1'b1;
  logic        startSave = 1'b0;
  logic        startRestore = 1'b0;
  logic        memReady = 1'b0;
  logic [4:0]  rbReadAddy;
  logic [31:0] rbData;
  logic [4:0]  rbWriteAddy;
  logic [31:0] rbWriteData;
  logic        rbWriteReg;
  logic [31:0] memAddr;
  logic [31:0] memWdata;
  logic        memWrite;
  logic        memRead;
  logic [31:0] memRdata;
  logic        cuStall;
  logic        busySave;
  logic        done;

  // Second instance with a short register range.
  logic        start2Save = 1'b0;
  logic        start2Restore = 1'b0;
  logic        mem2Ready = 1'b0;
  logic [4:0]  rb2ReadAddy;
  logic [31:0] rb2Data;
  logic [4:0]  rb2WriteAddy;
  logic [31:0] rb2WriteData;
  logic        rb2WriteReg;
  logic [31:0] mem2Addr;
  logic [31:0] mem2Wdata;
  logic        mem2Write;
  logic        mem2Read;
  logic [31:0] mem2Rdata;
  logic        cu2Stall;
  logic        busy2Save;
  logic        done2;

  reg_context_seq dut (
    .clock(clock), .reset(reset), .start_save(startSave), .start_restore(startRestore),
    .rb_readAddy(rbReadAddy), .rb_data(rbData), .rb_writeAddy(rbWriteAddy),
    .rb_writeData(rbWriteData), .rb_writeReg(rbWriteReg), .mem_addr(memAddr),
    .mem_wdata(memWdata), .mem_write(memWrite), .mem_read(memRead), .mem_rdata(memRdata),
    .mem_ready(memReady), .cu_stall(cuStall), .busy_save(busySave), .done(done)
  );

  reg_context_seq #(.BASE_ADDR(32'h0000_0F00), .FIRST_REG(29), .LAST_REG(31)) dut2 (
    .clock(clock), .reset(reset), .start_save(start2Save), .start_restore(start2Restore),
    .rb_readAddy(rb2ReadAddy), .rb_data(rb2Data), .rb_writeAddy(rb2WriteAddy),
    .rb_writeData(rb2WriteData), .rb_writeReg(rb2WriteReg), .mem_addr(mem2Addr),
    .mem_wdata(mem2Wdata), .mem_write(mem2Write), .mem_read(mem2Read), .mem_rdata(mem2Rdata),
    .mem_ready(mem2Ready), .cu_stall(cu2Stall), .busy_save(busy2Save), .done(done2)
  );

  // Models: register bench, frame memory and reference values.
  logic [31:0] regs [32];
  logic [31:0] frame [32];
  logic [31:0] expRegs [32];
  logic        tbWe = 1'b0;
  logic [4:0]  tbWa = '0;
  logic [31:0] tbWd = '0;

  assign rbData    = regs[rbReadAddy];
  assign rb2Data   = regs[rb2ReadAddy];
  assign memRdata  = frame[5'((memAddr - BASE) >> 2)];
  assign mem2Rdata = frame[5'((mem2Addr - BASE) >> 2)];

  logic [31:0] storeAddrQ[$];
  logic [31:0] storeDataQ[$];
  logic [31:0] store2AddrQ[$];
  logic [31:0] store2DataQ[$];
  logic [4:0]  wr2AddrQ[$];
  logic [31:0] wr2DataQ[$];
  int stallCycles = 0, busyCycles = 0, doneCount = 0, done2Count = 0;
  int writeReqCycles = 0, readReqCycles = 0, regWrites = 0;
  int overlapErr = 0, protoErr = 0, zeroWrites = 0;
  logic        prevPend = 1'b0;
  logic        prevWrite = 1'b0;
  logic [31:0] prevAddr = '0;
  logic [31:0] prevData = '0;

  // Bench writes, transfer logging and protocol monitoring.
  always @(posedge clock) begin
    if (rbWriteReg) begin
      regs[rbWriteAddy] <= rbWriteData;
      regWrites <= regWrites + 1;
      if (rbWriteAddy == 5'd0) zeroWrites <= zeroWrites + 1;
    end else if (tbWe) begin
      regs[tbWa] <= tbWd;
    end
    if (memWrite && memReady) begin
      storeAddrQ.push_back(memAddr);
      storeDataQ.push_back(memWdata);
    end
    if (mem2Write && mem2Ready) begin
      store2AddrQ.push_back(mem2Addr);
      store2DataQ.push_back(mem2Wdata);
    end
    if (rb2WriteReg) begin
      wr2AddrQ.push_back(rb2WriteAddy);
      wr2DataQ.push_back(rb2WriteData);
    end
    if (cuStall) stallCycles <= stallCycles + 1;
    if (busySave) busyCycles <= busyCycles + 1;
    if (done) doneCount <= doneCount + 1;
    if (done2) done2Count <= done2Count + 1;
    if (memWrite) writeReqCycles <= writeReqCycles + 1;
    if (memRead) readReqCycles <= readReqCycles + 1;
    if ((memRead && rbWriteReg) || (memRead && memWrite)) overlapErr <= overlapErr + 1;
    if (!reset && prevPend) begin
      if (prevWrite ? !memWrite : !memRead) protoErr <= protoErr + 1;
      else if (memAddr != prevAddr || (prevWrite && memWdata != prevData)) protoErr <= protoErr + 1;
    end
    prevPend  <= !reset && (memWrite || memRead) && !memReady;
    prevWrite <= memWrite;
    prevAddr  <= memAddr;
    prevData  <= memWdata;
  end

  int total = 0;
  int bad = 0;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Copy the reference register values into the bench model.
  task automatic preload();
    for (int i = 0; i < 32; i++) begin
      tbWe = 1'b1; tbWa = 5'(i); tbWd = expRegs[i];
      tick();
    end
    tbWe = 1'b0;
  endtask

  // mode 0: ready always high; 1: two low cycles then one high per request; 2: random.
  task automatic runUntilDone(input int budget, input int mode, output int latency);
    int phase;
    phase = 0;
    latency = -1;
    for (int c = 1; c <= budget; c++) begin
      case (mode)
        0: memReady = 1'b1;
        1: begin
          if (memWrite || memRead) begin
            memReady = (phase == 2);
            phase = (phase == 2) ? 0 : phase + 1;
          end else begin
            memReady = 1'b0;
          end
        end
        default: memReady = 1'($urandom % 2);
      endcase
      tick();
      if (done) begin
        latency = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; startSave = 1'b1; memReady = 1'b1;
    tick(); tick();
    total++; if ({cuStall, busySave, done, memWrite, memRead, rbWriteReg} !== 6'b0) begin
      bad++; $display("FAIL reset_flags got=%b exp=000000", {cuStall, busySave, done, memWrite, memRead, rbWriteReg});
    end
    total++; if (memAddr !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h exp=0", memAddr); end
    reset = 1'b0; startSave = 1'b0; memReady = 1'b0;
    tick(); tick();
    total++; if (cuStall !== 1'b0 || doneCount !== 0) begin
      bad++; $display("FAIL idle_after_reset stall=%b done=%0d exp 0/0", cuStall, doneCount);
    end
  endtask

  task automatic test_save_fast();
    int lat, s0, st0, b0, d0;
    for (int i = 0; i < 32; i++) expRegs[i] = 32'h100 + i;
    preload();
    s0 = storeAddrQ.size(); st0 = stallCycles; b0 = busyCycles; d0 = doneCount;
    startSave = 1'b1; tick(); startSave = 1'b0;
    runUntilDone(100, 0, lat);
    tick();
    total++; if (lat !== 31) begin bad++; $display("FAIL save_latency got=%0d exp=31", lat); end
    total++; if (storeAddrQ.size() - s0 !== 31) begin bad++; $display("FAIL save_count got=%0d exp=31", storeAddrQ.size() - s0); end
    for (int k = 0; k < 31 && s0 + k < storeAddrQ.size(); k++) begin
      total++; if (storeAddrQ[s0+k] !== BASE + 32'(4*k) || storeDataQ[s0+k] !== 32'h101 + 32'(k)) begin
        bad++; $display("FAIL save_word%0d got=%h/%h exp=%h/%h", k, storeAddrQ[s0+k], storeDataQ[s0+k], BASE + 32'(4*k), 32'h101 + 32'(k));
      end
    end
    total++; if (stallCycles - st0 !== 32) begin bad++; $display("FAIL save_stall got=%0d exp=32", stallCycles - st0); end
    total++; if (busyCycles - b0 !== 31) begin bad++; $display("FAIL save_busy got=%0d exp=31", busyCycles - b0); end
    total++; if (doneCount - d0 !== 1) begin bad++; $display("FAIL save_done got=%0d exp=1", doneCount - d0); end
  endtask

  task automatic test_save_stall();
    int lat, s0, w0, p0;
    for (int i = 0; i < 32; i++) expRegs[i] = $urandom;
    preload();
    s0 = storeAddrQ.size(); w0 = writeReqCycles; p0 = protoErr;
    startSave = 1'b1; tick(); startSave = 1'b0;
    runUntilDone(400, 1, lat);
    tick();
    total++; if (writeReqCycles - w0 !== 93) begin bad++; $display("FAIL stall_reqcycles got=%0d exp=93", writeReqCycles - w0); end
    total++; if (protoErr - p0 !== 0) begin bad++; $display("FAIL stall_stability got=%0d exp=0", protoErr - p0); end
    total++; if (storeAddrQ.size() - s0 !== 31) begin bad++; $display("FAIL stall_count got=%0d exp=31", storeAddrQ.size() - s0); end
    for (int k = 0; k < 31 && s0 + k < storeAddrQ.size(); k++) begin
      total++; if (storeAddrQ[s0+k] !== BASE + 32'(4*k) || storeDataQ[s0+k] !== expRegs[k+1]) begin
        bad++; $display("FAIL stall_word%0d got=%h/%h exp=%h/%h", k, storeAddrQ[s0+k], storeDataQ[s0+k], BASE + 32'(4*k), expRegs[k+1]);
      end
    end
  endtask

  task automatic test_restore();
    int lat, w0, st0, o0, z0;
    for (int i = 0; i < 32; i++) begin
      expRegs[i] = $urandom;
      frame[i] = 32'hA000 + i;
    end
    preload();
    w0 = regWrites; st0 = stallCycles; o0 = overlapErr; z0 = zeroWrites;
    startRestore = 1'b1; tick(); startRestore = 1'b0;
    runUntilDone(200, 0, lat);
    tick();
    total++; if (lat !== 62) begin bad++; $display("FAIL restore_latency got=%0d exp=62", lat); end
    total++; if (regWrites - w0 !== 31) begin bad++; $display("FAIL restore_writes got=%0d exp=31", regWrites - w0); end
    total++; if (stallCycles - st0 !== 63) begin bad++; $display("FAIL restore_stall got=%0d exp=63", stallCycles - st0); end
    total++; if (overlapErr - o0 !== 0) begin bad++; $display("FAIL restore_overlap got=%0d exp=0", overlapErr - o0); end
    total++; if (zeroWrites - z0 !== 0 || regs[0] !== expRegs[0]) begin
      bad++; $display("FAIL restore_r0 got=%h exp=%h", regs[0], expRegs[0]);
    end
    for (int i = 1; i < 32; i++) begin
      total++; if (regs[i] !== 32'hA000 + 32'(i - 1)) begin
        bad++; $display("FAIL restore_r%0d got=%h exp=%h", i, regs[i], 32'hA000 + 32'(i - 1));
      end
    end
  endtask

  task automatic test_restore_random_ready();
    int lat, d0, o0, p0;
    for (int i = 0; i < 32; i++) begin
      expRegs[i] = $urandom;
      frame[i] = $urandom;
    end
    preload();
    d0 = doneCount; o0 = overlapErr; p0 = protoErr;
    startRestore = 1'b1; tick(); startRestore = 1'b0;
    runUntilDone(600, 2, lat);
    tick();
    total++; if (lat < 62) begin bad++; $display("FAIL rnd_restore_latency got=%0d exp>=62", lat); end
    total++; if (doneCount - d0 !== 1) begin bad++; $display("FAIL rnd_restore_done got=%0d exp=1", doneCount - d0); end
    total++; if (overlapErr - o0 !== 0 || protoErr - p0 !== 0) begin
      bad++; $display("FAIL rnd_restore_protocol got=%0d/%0d exp=0/0", overlapErr - o0, protoErr - p0);
    end
    for (int i = 1; i < 32; i++) begin
      total++; if (regs[i] !== frame[i-1]) begin bad++; $display("FAIL rnd_restore_r%0d got=%h exp=%h", i, regs[i], frame[i-1]); end
      expRegs[i] = frame[i-1];
    end
  endtask

  task automatic test_back_to_back();
    int lat, s0, d0, r0, w0;
    s0 = storeAddrQ.size(); d0 = doneCount; r0 = readReqCycles; w0 = regWrites;
    memReady = 1'b1;
    startSave = 1'b1; startRestore = 1'b1; tick();
    startSave = 1'b0; startRestore = 1'b0; tick(); tick();
    startRestore = 1'b1; tick(); startRestore = 1'b0;
    runUntilDone(100, 0, lat);
    for (int c = 0; c < 80; c++) tick();
    total++; if (doneCount - d0 !== 1) begin bad++; $display("FAIL both_done got=%0d exp=1", doneCount - d0); end
    total++; if (storeAddrQ.size() - s0 !== 31) begin bad++; $display("FAIL both_stores got=%0d exp=31", storeAddrQ.size() - s0); end
    total++; if (readReqCycles - r0 !== 0 || regWrites - w0 !== 0) begin
      bad++; $display("FAIL both_no_restore got=%0d/%0d exp=0/0", readReqCycles - r0, regWrites - w0);
    end
    total++; if (cuStall !== 1'b0) begin bad++; $display("FAIL both_idle got=%b exp=0", cuStall); end
  endtask

  task automatic test_reset_mid();
    int lat, s0;
    logic found;
    for (int i = 0; i < 32; i++) begin
      expRegs[i] = $urandom;
      frame[i] = $urandom;
    end
    preload();
    found = 1'b0;
    startRestore = 1'b1; tick(); startRestore = 1'b0;
    for (int c = 0; c < 100; c++) begin
      memReady = 1'b1;
      tick();
      if (rbWriteReg && rbWriteAddy == 5'd10) begin
        found = 1'b1;
        break;
      end
    end
    total++; if (found !== 1'b1) begin bad++; $display("FAIL midreset_reach got=%b exp=1", found); end
    reset = 1'b1;
    #1;
    total++; if (rbWriteReg !== 1'b0) begin bad++; $display("FAIL midreset_gate got=%b exp=0", rbWriteReg); end
    tick();
    total++; if ({cuStall, busySave, done, memWrite, memRead, rbWriteReg} !== 6'b0 || memAddr !== 32'h0) begin
      bad++; $display("FAIL midreset_outputs got=%b/%h exp=000000/0", {cuStall, busySave, done, memWrite, memRead, rbWriteReg}, memAddr);
    end
    reset = 1'b0;
    for (int c = 0; c < 5; c++) tick();
    total++; if (cuStall !== 1'b0) begin bad++; $display("FAIL midreset_idle got=%b exp=0", cuStall); end
    for (int i = 1; i < 10; i++) expRegs[i] = frame[i-1];
    total++; if (regs[10] !== expRegs[10]) begin bad++; $display("FAIL midreset_r10 got=%h exp=%h", regs[10], expRegs[10]); end
    total++; if (regs[9] !== expRegs[9]) begin bad++; $display("FAIL midreset_r9 got=%h exp=%h", regs[9], expRegs[9]); end
    s0 = storeAddrQ.size();
    startSave = 1'b1; tick(); startSave = 1'b0;
    runUntilDone(100, 0, lat);
    tick();
    total++; if (storeAddrQ.size() - s0 !== 31) begin bad++; $display("FAIL midreset_save_count got=%0d exp=31", storeAddrQ.size() - s0); end
    for (int k = 0; k < 31 && s0 + k < storeAddrQ.size(); k++) begin
      total++; if (storeAddrQ[s0+k] !== BASE + 32'(4*k) || storeDataQ[s0+k] !== expRegs[k+1]) begin
        bad++; $display("FAIL midreset_word%0d got=%h/%h exp=%h/%h", k, storeAddrQ[s0+k], storeDataQ[s0+k], BASE + 32'(4*k), expRegs[k+1]);
      end
    end
  endtask

  task automatic test_short_range();
    int s0, w0, d0;
    logic seen;
    s0 = store2AddrQ.size(); w0 = wr2AddrQ.size(); d0 = done2Count;
    mem2Ready = 1'b1;
    start2Save = 1'b1; tick(); start2Save = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin tick(); seen = done2; end
    tick();
    total++; if (seen !== 1'b1 || store2AddrQ.size() - s0 !== 3) begin
      bad++; $display("FAIL short_save_count got=%0d done=%b exp=3/1", store2AddrQ.size() - s0, seen);
    end
    for (int k = 0; k < 3 && s0 + k < store2AddrQ.size(); k++) begin
      total++; if (store2AddrQ[s0+k] !== BASE + 32'(4*k) || store2DataQ[s0+k] !== regs[29+k]) begin
        bad++; $display("FAIL short_save_word%0d got=%h/%h exp=%h/%h", k, store2AddrQ[s0+k], store2DataQ[s0+k], BASE + 32'(4*k), regs[29+k]);
      end
    end
    start2Restore = 1'b1; tick(); start2Restore = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 30 && !seen; c++) begin tick(); seen = done2; end
    tick();
    total++; if (wr2AddrQ.size() - w0 !== 3) begin bad++; $display("FAIL short_restore_count got=%0d exp=3", wr2AddrQ.size() - w0); end
    for (int k = 0; k < 3 && w0 + k < wr2AddrQ.size(); k++) begin
      total++; if (wr2AddrQ[w0+k] !== 5'(29 + k) || wr2DataQ[w0+k] !== frame[k]) begin
        bad++; $display("FAIL short_restore_word%0d got=%0d/%h exp=%0d/%h", k, wr2AddrQ[w0+k], wr2DataQ[w0+k], 29 + k, frame[k]);
      end
    end
    total++; if (done2Count - d0 !== 2) begin bad++; $display("FAIL short_done got=%0d exp=2", done2Count - d0); end
  endtask

  // Run every scenario in sequence and report.
  initial begin
    test_reset();
    test_save_fast();
    test_save_stall();
    test_restore();
    test_restore_random_ready();
    test_back_to_back();
    test_reset_mid();
    test_short_range();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Stop a run that has stalled.
  initial begin
    #2000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] timeout");
  end

endmodule
